// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD core: controller state encoding and default operand width.
package gcd_pkg;

  localparam int unsigned DefaultWidth = 8;

  // Encoding 2'd3 is unused and recovers to StIdle.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } gcd_state_e;

endpackage

// File: rtl/gcd_cmp.sv
// Magnitude comparator for the GCD datapath: exactly one of eq/lt/gt is high.
module gcd_cmp #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  output logic             eq_out,
  output logic             lt_out,
  output logic             gt_out
);

  always_comb begin
    eq_out = (x_in == y_in);
    lt_out = (x_in < y_in);
    gt_out = (x_in > y_in);
  end

endmodule

// File: rtl/gcd_sequencer.sv
// GCD by repeated subtraction with valid/ready handshakes; one operation in flight at a time.
module gcd_sequencer
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd_out,
  output logic             zero_flag,
  output logic [WIDTH-1:0] iter_cnt
);

  gcd_state_e       state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic [WIDTH-1:0] iter_q, iter_d;
  logic             zero_q, zero_d;
  logic             eq, lt, gt;

  gcd_cmp #(
    .WIDTH(WIDTH)
  ) u_cmp (
    .x_in  (x_q),
    .y_in  (y_q),
    .eq_out(eq),
    .lt_out(lt),
    .gt_out(gt)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    gcd_d   = gcd_q;
    iter_d  = iter_q;
    zero_d  = zero_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d    = a_in;
          y_d    = b_in;
          iter_d = '0;
          if (a_in == '0 || b_in == '0) begin
            // gcd(n,0) = n, and gcd(0,0) is reported as 0.
            gcd_d   = a_in | b_in;
            zero_d  = 1'b1;
            state_d = StDone;
          end else begin
            zero_d  = 1'b0;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (gt) begin
          x_d    = x_q - y_q;
          iter_d = iter_q + WIDTH'(1);
        end else if (lt) begin
          y_d    = y_q - x_q;
          iter_d = iter_q + WIDTH'(1);
        end else if (eq) begin
          gcd_d   = x_q;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      gcd_q   <= '0;
      iter_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      gcd_q   <= gcd_d;
      iter_q  <= iter_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    gcd_out   = gcd_q;
    zero_flag = zero_q;
    iter_cnt  = iter_q;
  end

endmodule

// File: tb/tb_gcd_sequencer.sv
// Randomized and directed bench for gcd_sequencer against an Euclid-quotient reference model.
module tb_gcd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] gcd_out;
  logic       zero_flag;
  logic [7:0] iter_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  gcd_sequencer #(
    .WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_in     (a_in),
    .b_in     (b_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .gcd_out  (gcd_out),
    .zero_flag(zero_flag),
    .iter_cnt (iter_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  // Subtraction count equals the sum of Euclid quotients minus the final one's extra step.
  function automatic void ref_gcd(input int a, input int b, output int g, output int z,
                                  output int it);
    int x, y, t;
    it = 0;
    if (a == 0 || b == 0) begin
      g = a | b;
      z = 1;
    end else begin
      z = 0;
      x = a;
      y = b;
      while (y != 0) begin
        it += x / y;
        t = x % y;
        x = y;
        y = t;
      end
      it -= 1;
      g = x;
    end
  endfunction

  task automatic run_op(input int a, input int b, input int hold, input string tag);
    int g, z, it, lat, exp_lat;
    logic [7:0] g0, i0;
    logic       z0;
    ref_gcd(a, b, g, z, it);
    exp_lat = (z != 0) ? 0 : it + 1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_ready_before: got %b want 1", tag, in_ready);
    end
    in_valid = 1'b1;
    a_in = 8'(a);
    b_in = 8'(b);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a_in = 8'($urandom);
    b_in = 8'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat != exp_lat) begin
      n_bad++;
      $display("FAIL %s_latency: got %0d want %0d (a=%0d b=%0d)", tag, lat, exp_lat, a, b);
    end
    n_cmp++;
    if (gcd_out !== 8'(g)) begin
      n_bad++;
      $display("FAIL %s_gcd: got %0d want %0d (a=%0d b=%0d)", tag, gcd_out, g, a, b);
    end
    n_cmp++;
    if (zero_flag !== 1'(z)) begin
      n_bad++;
      $display("FAIL %s_zero_flag: got %b want %0d (a=%0d b=%0d)", tag, zero_flag, z, a, b);
    end
    n_cmp++;
    if (iter_cnt !== 8'(it)) begin
      n_bad++;
      $display("FAIL %s_iter: got %0d want %0d (a=%0d b=%0d)", tag, iter_cnt, it, a, b);
    end
    g0 = 8'(g);
    i0 = 8'(it);
    z0 = 1'(z);
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b1 || gcd_out !== g0 || iter_cnt !== i0 || zero_flag !== z0
          || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL %s_hold%0d: got v=%b g=%0d i=%0d z=%b r=%b want v=1 g=%0d i=%0d z=%b r=0",
                 tag, k, out_valid, gcd_out, iter_cnt, zero_flag, in_ready, g0, i0, z0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_after_hs: got v=%b r=%b want v=0 r=1", tag, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    a_in = 8'd7;
    b_in = 8'd3;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || gcd_out !== 8'd0 || zero_flag !== 1'b0
        || iter_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_state: got v=%b r=%b g=%0d z=%b i=%0d want v=0 r=1 g=0 z=0 i=0",
               out_valid, in_ready, gcd_out, zero_flag, iter_cnt);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_basic();
    run_op(12, 8, 0, "basic_12_8");
    run_op(21, 35, 0, "basic_21_35");
  endtask

  task automatic test_zero();
    run_op(0, 5, 0, "zero_0_5");
    run_op(0, 0, 0, "zero_0_0");
    run_op(9, 0, 0, "zero_9_0");
  endtask

  task automatic test_boundary();
    run_op(255, 1, 0, "bound_255_1");
    run_op(37, 37, 0, "bound_37_37");
    run_op(1, 255, 0, "bound_1_255");
  endtask

  task automatic test_backpressure();
    run_op(48, 18, 5, "bp_48_18");
  endtask

  task automatic test_ignore_in_valid();
    int g, z, it, cyc;
    ref_gcd(35, 14, g, z, it);
    @(negedge clk);
    in_valid = 1'b1;
    a_in = 8'd35;
    b_in = 8'd14;
    @(posedge clk);
    @(negedge clk);
    a_in = 8'd9;
    b_in = 8'd3;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL ign_ready_run: got %b want 0", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 300) begin
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL ign_ready_c%0d: got %b want 0", cyc, in_ready);
      end
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (out_valid !== 1'b1 || gcd_out !== 8'(g) || iter_cnt !== 8'(it)) begin
      n_bad++;
      $display("FAIL ign_result: got v=%b g=%0d i=%0d want v=1 g=%0d i=%0d",
               out_valid, gcd_out, iter_cnt, g, it);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ign_after_hs: got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    in_valid = 1'b1;
    a_in = 8'd200;
    b_in = 8'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || gcd_out !== 8'd0 || zero_flag !== 1'b0
        || iter_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL midrst_state: got v=%b r=%b g=%0d z=%b i=%0d want v=0 r=1 g=0 z=0 i=0",
               out_valid, in_ready, gcd_out, zero_flag, iter_cnt);
    end
    run_op(21, 6, 0, "midrst_21_6");
  endtask

  task automatic test_random();
    int a, b;
    for (int n = 0; n < 24; n++) begin
      a = (($urandom % 8) == 0) ? 0 : int'($urandom_range(1, 255));
      b = (($urandom % 8) == 0) ? 0 : int'($urandom_range(1, 255));
      run_op(a, b, int'($urandom_range(0, 2)), $sformatf("rnd%0d", n));
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    a_in = '0;
    b_in = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_zero();
    test_boundary();
    test_backpressure();
    test_ignore_in_valid();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
